usb_fs_tx: RTL and testbench

USB_FS_TX -- requirements
Module: usb_fs_tx

---
 rtl/usb_fs_tx.sv | 216 +++++++++++++++++++++
 tb/tb_usb_fs_tx.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_tx.sv
// usb_fs_tx - full-speed USB packet transmitter.
//
// Sends SYNC, PID, an optional payload and CRC16, then EOP, as an NRZI
// line with bit stuffing. Each bit lasts 4 clocks, so a 48 MHz clock gives
// 12 Mb/s.
//
// Ports
//   clk_48mhz      in   sole clock; all state changes on the rising edge
//   reset_n        in   asynchronous reset, active low
//   pkt_start      in   one-cycle request to send; only looked at in IDLE
//   pid[3:0]       in   packet PID; captured together with pkt_start
//   tx_data_avail  in   another payload byte is waiting on tx_data
//   tx_data[7:0]   in   payload byte
//   tx_data_get    out  tx_data is taken in this cycle
//   oe             out  pad output enable
//   dp, dn         out  line state: J = 10, K = 01, SE0 = 00
//   busy           out  a packet is in progress
//   pkt_end        out  one-cycle pulse after the last EOP clock
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line idle at J, oe low, waiting for pkt_start
// SYNC  | sending 8'h80, LSB first
// PID   | sending {~pid, pid}
// DATA  | sending payload bytes, CRC16 updated on every data bit
// CRC16 | sending the complemented CRC register, bit 15 first
// EOP   | two bit periods of SE0, then one bit period of J

module usb_fs_tx (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic       pkt_start,
  input  logic [3:0] pid,
  input  logic       tx_data_avail,
  input  logic [7:0] tx_data,
  output logic       tx_data_get,
  output logic       oe,
  output logic       dp,
  output logic       dn,
  output logic       busy,
  output logic       pkt_end
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_PID   = 3'd2,
    S_DATA  = 3'd3,
    S_CRC16 = 3'd4,
    S_EOP   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [1:0]  r_clk_cnt;   // clocks left in the current bit period
  logic [3:0]  r_bit_cnt;   // bits left in the current field after this one
  logic [7:0]  r_shift;     // byte being sent; bit 0 is on the line
  logic [15:0] r_crc;
  logic [3:0]  r_pid;
  logic [2:0]  r_ones;      // consecutive data 1s sent so far
  logic        r_stuff;     // the current bit period is a stuffed 0
  logic        r_line;      // 1 = J, 0 = K
  logic        r_pkt_end;

  logic        w_cur_bit;
  logic        w_bit_end;
  logic [2:0]  w_ones_after;
  logic        w_stuff_nxt;
  logic        w_advance;
  logic        w_field_end;
  logic        w_pid_is_data;
  logic        w_crc_fb;
  logic [15:0] w_crc_nxt;
  logic        w_nxt_bit;

  assign w_cur_bit     = (r_state == S_CRC16) ? ~r_crc[15] : r_shift[0];
  assign w_bit_end     = (r_state != S_IDLE) && (r_clk_cnt == 2'd0);
  assign w_ones_after  = (r_stuff || !w_cur_bit) ? 3'd0 : (r_ones + 3'd1);
  // A stuffed bit takes priority over moving on, so the field (and any
  // byte load) advances only at the end of the stuffed period.
  assign w_stuff_nxt   = w_bit_end && (r_state != S_EOP) && (w_ones_after == 3'd6);
  assign w_advance     = w_bit_end && !w_stuff_nxt;
  assign w_field_end   = w_advance && (r_bit_cnt == 4'd0);
  assign w_pid_is_data = (r_pid[1:0] == 2'b11);

  // Serial CRC16 (x^16+x^15+x^2+1) over payload bits only.
  assign w_crc_fb  = w_cur_bit ^ r_crc[15];
  assign w_crc_nxt = ((r_state == S_DATA) && !r_stuff)
                   ? ({r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h8005 : 16'h0000))
                   : r_crc;

  // State register
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (pkt_start) w_state_nxt = S_SYNC;
      S_SYNC:  if (w_field_end) w_state_nxt = S_PID;
      S_PID:   if (w_field_end) begin
                 if (!w_pid_is_data)    w_state_nxt = S_EOP;
                 else if (tx_data_avail) w_state_nxt = S_DATA;
                 else                    w_state_nxt = S_CRC16;
               end
      S_DATA:  if (w_field_end) w_state_nxt = tx_data_avail ? S_DATA : S_CRC16;
      S_CRC16: if (w_field_end) w_state_nxt = S_EOP;
      S_EOP:   if (w_field_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Data bit that will be on the line after an advance.
  always_comb begin
    w_nxt_bit = 1'b1;
    if (w_field_end) begin
      case (w_state_nxt)
        S_PID:   w_nxt_bit = r_pid[0];
        S_DATA:  w_nxt_bit = tx_data[0];
        S_CRC16: w_nxt_bit = ~w_crc_nxt[15];
        default: w_nxt_bit = 1'b1;
      endcase
    end else if (r_state == S_CRC16) begin
      w_nxt_bit = ~r_crc[14];
    end else begin
      w_nxt_bit = r_shift[1];
    end
  end

  // Bit timing, shifting, stuffing and NRZI line state
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_cnt <= 2'd3;
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'h00;
      r_crc     <= 16'hFFFF;
      r_pid     <= 4'h0;
      r_ones    <= 3'd0;
      r_stuff   <= 1'b0;
      r_line    <= 1'b1;
      r_pkt_end <= 1'b0;
    end else begin
      r_pkt_end <= 1'b0;
      if (r_state == S_IDLE) begin
        r_clk_cnt <= 2'd3;
        r_ones    <= 3'd0;
        r_stuff   <= 1'b0;
        r_line    <= 1'b1;
        if (pkt_start) begin
          // First SYNC bit is a 0, so the line leaves J for K right away.
          r_pid     <= pid;
          r_crc     <= 16'hFFFF;
          r_shift   <= 8'h80;
          r_bit_cnt <= 4'd7;
          r_line    <= 1'b0;
        end
      end else begin
        if (w_bit_end) begin
          r_clk_cnt <= 2'd3;
          r_ones    <= w_stuff_nxt ? 3'd0 : w_ones_after;
          r_crc     <= w_crc_nxt;
        end else begin
          r_clk_cnt <= r_clk_cnt - 2'd1;
        end

        if (w_stuff_nxt) begin
          r_stuff <= 1'b1;
          r_line  <= ~r_line;
        end else if (w_advance) begin
          r_stuff <= 1'b0;
          r_line  <= w_nxt_bit ? r_line : ~r_line;
          if (w_field_end) begin
            r_bit_cnt <= 4'd7;
            case (w_state_nxt)
              S_PID:   r_shift <= {~r_pid, r_pid};
              S_DATA:  r_shift <= tx_data;
              S_CRC16: r_bit_cnt <= 4'd15;
              S_EOP:   r_bit_cnt <= 4'd2;
              default: begin
                r_line    <= 1'b1;
                r_pkt_end <= 1'b1;
              end
            endcase
          end else begin
            r_bit_cnt <= r_bit_cnt - 4'd1;
            if (r_state == S_CRC16) r_crc   <= {r_crc[14:0], 1'b0};
            else                    r_shift <= {1'b0, r_shift[7:1]};
          end
        end
      end
    end
  end

  // Outputs
  always_comb begin
    oe          = (r_state != S_IDLE);
    busy        = (r_state != S_IDLE);
    dp          = r_line;
    dn          = ~r_line;
    tx_data_get = 1'b0;
    if (r_state == S_EOP) begin
      dp = (r_bit_cnt == 4'd0);
      dn = 1'b0;
    end
    if (w_field_end && tx_data_avail &&
        (((r_state == S_PID) && w_pid_is_data) || (r_state == S_DATA)))
      tx_data_get = 1'b1;
  end

  assign pkt_end = r_pkt_end;

endmodule

// File: tb/tb_usb_fs_tx.sv
// tb_usb_fs_tx - directed bench for usb_fs_tx. The expected line is built
// from an independent model (reflected CRC16, stuffing, NRZI) and compared
// sample by sample; short packets are also checked against hand lengths.

module tb_usb_fs_tx;
  logic       clk_48mhz = 1'b0;
  logic       reset_n;
  logic       pkt_start;
  logic [3:0] pid;
  logic       tx_data_avail;
  logic [7:0] tx_data;
  logic       tx_data_get;
  logic       oe;
  logic       dp;
  logic       dn;
  logic       busy;
  logic       pkt_end;

  usb_fs_tx dut (
    .clk_48mhz     (clk_48mhz),
    .reset_n       (reset_n),
    .pkt_start     (pkt_start),
    .pid           (pid),
    .tx_data_avail (tx_data_avail),
    .tx_data       (tx_data),
    .tx_data_get   (tx_data_get),
    .oe            (oe),
    .dp            (dp),
    .dn            (dn),
    .busy          (busy),
    .pkt_end       (pkt_end)
  );

  always #10 clk_48mhz = ~clk_48mhz;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Payload source
  logic [7:0] pay [0:63];
  int         pay_len  = 0;
  int         get_base = 0;

  // Monitor state (written only by the monitor)
  int         cyc       = 0;
  logic [1:0] cap_q[$];
  int         n_get_tot = 0;
  int         n_pe_tot  = 0;
  int         get_pos[$];
  int         get_cyc[$];

  // Per-test bases and model results (written only by the main sequence)
  int         cap_base = 0;
  int         pe_base  = 0;
  logic [1:0] exp_sym[$];
  int         exp_first[$];
  logic [7:0] rx_bytes[$];

  always @(negedge clk_48mhz) begin
    cyc++;
    if (oe) cap_q.push_back({dp, dn});
    if (pkt_end) n_pe_tot++;
    if (tx_data_get) begin
      n_get_tot++;
      get_pos.push_back(cap_q.size());
      get_cyc.push_back(cyc);
    end
  end

  // Present the next byte just after the edge that consumed the previous one.
  always @(posedge clk_48mhz) begin
    int idx;
    #1;
    idx = n_get_tot - get_base;
    tx_data_avail = (idx < pay_len);
    tx_data       = (idx >= 0 && idx < 64) ? pay[idx] : 8'h00;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic build_exp(input logic [3:0] p, input int n);
    logic [7:0]  b;
    logic [15:0] c;
    bit          bits[$];
    int          first_idx[$];
    bit          line;
    int          ones;
    int          k;
    exp_sym.delete();
    exp_first.delete();
    b = 8'h80;
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    b = {~p, p};
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (p[1:0] == 2'b11) begin
      c = 16'hFFFF;
      for (int j = 0; j < n; j++) begin
        first_idx.push_back(bits.size());
        b = pay[j];
        for (int i = 0; i < 8; i++) begin
          bits.push_back(b[i]);
          if (c[0] ^ b[i]) c = (c >> 1) ^ 16'hA001;
          else             c = c >> 1;
        end
      end
      c = ~c;
      for (int i = 0; i < 16; i++) bits.push_back(c[i]);
    end
    line = 1'b1;
    ones = 0;
    k    = 0;
    for (int i = 0; i < bits.size(); i++) begin
      if (k < first_idx.size() && first_idx[k] == i) begin
        exp_first.push_back(exp_sym.size());
        k++;
      end
      if (!bits[i]) line = ~line;
      exp_sym.push_back(line ? 2'b10 : 2'b01);
      ones = bits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        line = ~line;
        exp_sym.push_back(line ? 2'b10 : 2'b01);
        ones = 0;
      end
    end
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b10);
  endtask

  task automatic setup(input logic [3:0] p, input int n, input int avail_len);
    build_exp(p, n);
    @(negedge clk_48mhz);
    pay_len  = avail_len;
    get_base = n_get_tot;
    pe_base  = n_pe_tot;
    cap_base = cap_q.size();
    @(posedge clk_48mhz);
    @(negedge clk_48mhz);
  endtask

  task automatic start_pkt(input logic [3:0] p, input string tag);
    @(negedge clk_48mhz);
    pid       = p;
    pkt_start = 1'b1;
    @(negedge clk_48mhz);
    pkt_start = 1'b0;
    pid       = ~p;
    chk({tag, "_oe_first"}, oe, 1'b1);
    chk({tag, "_line_first"}, {dp, dn}, 2'b01);
  endtask

  task automatic wait_end(input string tag);
    int k = 0;
    while ((n_pe_tot - pe_base) == 0 && k < 6000) begin
      @(negedge clk_48mhz);
      k++;
    end
    chk({tag, "_done"}, ((n_pe_tot - pe_base) != 0), 1'b1);
    repeat (4) @(negedge clk_48mhz);
  endtask

  task automatic check_pkt(input string tag, input int exp_oe, input int exp_gets);
    int len;
    int mism;
    int ng;
    len  = cap_q.size() - cap_base;
    mism = 0;
    chk({tag, "_oe_len"}, len, 4 * exp_sym.size());
    if (exp_oe > 0) chk({tag, "_oe_hand"}, len, exp_oe);
    for (int i = 0; i < len; i++) begin
      if ((i / 4) >= exp_sym.size())              mism++;
      else if (cap_q[cap_base + i] !== exp_sym[i / 4]) mism++;
    end
    chk({tag, "_line_mism"}, mism, 0);
    chk({tag, "_pkt_end_cnt"}, n_pe_tot - pe_base, 1);
    ng = n_get_tot - get_base;
    chk({tag, "_get_cnt"}, ng, exp_gets);
    for (int k = 0; k < ng && k < exp_first.size(); k++)
      chk({tag, "_get_pos"}, get_pos[get_base + k] - cap_base, 4 * exp_first[k]);
    chk({tag, "_busy_after"}, busy, 1'b0);
    chk({tag, "_oe_after"}, oe, 1'b0);
  endtask

  // Receiver: NRZI decode at mid-bit, drop stuffed bits, group into bytes.
  task automatic decode(output logic [3:0] rpid);
    bit         bits[$];
    logic [1:0] prev;
    logic [1:0] sym;
    logic [7:0] b;
    int         ones;
    int         nsym;
    bit         bv;
    rx_bytes.delete();
    prev = 2'b10;
    ones = 0;
    nsym = (cap_q.size() - cap_base) / 4;
    for (int s = 0; s < nsym - 3; s++) begin
      sym  = cap_q[cap_base + 4 * s + 1];
      bv   = (sym == prev);
      prev = sym;
      if (ones == 6) begin
        ones = 0;
        continue;
      end
      bits.push_back(bv);
      ones = bv ? ones + 1 : 0;
    end
    rpid = 4'h0;
    if (bits.size() >= 16)
      for (int i = 0; i < 4; i++) rpid[i] = bits[8 + i];
    for (int j = 16; j + 8 <= bits.size(); j += 8) begin
      for (int i = 0; i < 8; i++) b[i] = bits[j + i];
      rx_bytes.push_back(b);
    end
  endtask

  initial begin
    logic [3:0] rpid;
    int         mism;
    int         k;
    int         c;

    reset_n   = 1'b0;
    pkt_start = 1'b0;
    pid       = 4'h0;
    for (int i = 0; i < 64; i++) pay[i] = 8'h00;
    repeat (3) @(negedge clk_48mhz);
    chk("rst_oe", oe, 1'b0);
    chk("rst_dp", dp, 1'b1);
    chk("rst_dn", dn, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pkt_end", pkt_end, 1'b0);
    chk("rst_get", tx_data_get, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_48mhz);

    // ACK: SYNC + PID only, 19 bit periods
    setup(4'h2, 0, 0);
    start_pkt(4'h2, "ack");
    wait_end("ack");
    check_pkt("ack", 76, 0);

    // Zero-length DATA1: CRC is 16 zeros
    setup(4'hB, 0, 0);
    start_pkt(4'hB, "zlp");
    wait_end("zlp");
    check_pkt("zlp", 140, 0);

    // DATA0 FF FF: stuffing inside and between bytes
    pay[0] = 8'hFF;
    pay[1] = 8'hFF;
    setup(4'h3, 2, 2);
    start_pkt(4'h3, "ff");
    wait_end("ff");
    check_pkt("ff", 0, 2);

    // Loopback of 64 bytes 00..3F
    for (int i = 0; i < 64; i++) pay[i] = i[7:0];
    setup(4'h3, 64, 64);
    start_pkt(4'h3, "lb");
    wait_end("lb");
    check_pkt("lb", 0, 64);
    decode(rpid);
    chk("lb_rx_pid", rpid, 4'h3);
    chk("lb_rx_nbytes", rx_bytes.size(), 66);
    mism = 0;
    for (int i = 0; i < 64; i++)
      if (i >= rx_bytes.size() || rx_bytes[i] !== i[7:0]) mism++;
    chk("lb_rx_payload", mism, 0);

    // pkt_start during CRC16 must be ignored
    pay[0] = 8'h01;
    pay[1] = 8'h02;
    setup(4'h3, 2, 2);
    start_pkt(4'h3, "ign");
    k = 0;
    while ((n_get_tot - get_base) < 2 && k < 2000) begin
      @(negedge clk_48mhz);
      k++;
    end
    chk("ign_gets_seen", ((n_get_tot - get_base) >= 2), 1'b1);
    c = (get_cyc.size() > 0) ? get_cyc[get_cyc.size() - 1] : cyc;
    k = 0;
    while (cyc < c + 50 && k < 200) begin
      @(negedge clk_48mhz);
      k++;
    end
    pid       = 4'h2;
    pkt_start = 1'b1;
    @(negedge clk_48mhz);
    pkt_start = 1'b0;
    wait_end("ign");
    repeat (300) @(negedge clk_48mhz);
    check_pkt("ign", 0, 2);

    // Reset in the middle of the payload
    for (int i = 0; i < 8; i++) pay[i] = 8'h10 + i[7:0];
    setup(4'h3, 8, 8);
    start_pkt(4'h3, "rst");
    k = 0;
    while ((n_get_tot - get_base) < 3 && k < 2000) begin
      @(negedge clk_48mhz);
      k++;
    end
    chk("rst_gets_seen", ((n_get_tot - get_base) >= 3), 1'b1);
    repeat (12) @(negedge clk_48mhz);
    chk("rst_mid_oe_before", oe, 1'b1);
    @(posedge clk_48mhz);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_oe", oe, 1'b0);
    chk("rst_mid_dp", dp, 1'b1);
    chk("rst_mid_dn", dn, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_get", tx_data_get, 1'b0);
    repeat (5) @(negedge clk_48mhz);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_48mhz);
    chk("rst_mid_no_pkt_end", n_pe_tot - pe_base, 0);

    // ACK after reset, with a byte pending: no payload, no tx_data_get
    setup(4'h2, 0, 2);
    start_pkt(4'h2, "ack2");
    wait_end("ack2");
    check_pkt("ack2", 76, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
